// File: rtl/ram_block_copy.sv
// Block copy / fill engine acting as a second bus master on the 1K-word RAM.
// Optional fill path is enabled by defining RAM_COPY_FILL_EN.
module ram_block_copy #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int PTR_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PTR_W-1:0]  src,
  input  logic [PTR_W-1:0]  dst,
  input  logic [PTR_W:0]    len,
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [PTR_W:0]    words_done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              select,
  output logic              write_enable
);

  // Handshake: start is a level sampled only in IDLE; busy covers RD..WR and
  // done pulses for exactly one cycle as the engine returns to IDLE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_HOLD = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [PTR_W-1:0]  src_ptr, src_ptr_n;
  logic [PTR_W-1:0]  dst_ptr, dst_ptr_n;
  logic [PTR_W:0]    remaining, remaining_n;
  logic [PTR_W:0]    words_done_n;
  logic [DATA_W-1:0] wr_data_n;
  logic [ADDR_W-1:0] addr_n;
  logic              busy_n, done_n, select_n, write_enable_n;
  logic              fill_q;

`ifdef RAM_COPY_FILL_EN
  logic fill_n;
`else
  logic unused_fill;
  assign fill_q      = 1'b0;
  assign unused_fill = ^{fill_mode, fill_data};
`endif

  always_comb begin
    state_n      = state;
    src_ptr_n    = src_ptr;
    dst_ptr_n    = dst_ptr;
    remaining_n  = remaining;
    words_done_n = words_done;
    wr_data_n    = wr_data;
`ifdef RAM_COPY_FILL_EN
    fill_n       = fill_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          src_ptr_n    = src;
          dst_ptr_n    = dst;
          remaining_n  = len;
          words_done_n = '0;
`ifdef RAM_COPY_FILL_EN
          fill_n = fill_mode;
          if (fill_mode) wr_data_n = fill_data;
          if (len == '0)     state_n = DONE;
          else if (fill_mode) state_n = WR;
          else               state_n = RD;
`else
          state_n = (len == '0) ? DONE : RD;
`endif
        end
      end
      RD:      state_n = RD_HOLD;
      RD_HOLD: begin
        // The RAM has re-read the same word, so rd_data is settled here.
        wr_data_n = rd_data;
        state_n   = WR;
      end
      WR: begin
        src_ptr_n    = src_ptr + 1'b1;
        dst_ptr_n    = dst_ptr + 1'b1;
        words_done_n = words_done + 1'b1;
        remaining_n  = remaining - 1'b1;
        if (remaining == (PTR_W+1)'(1)) state_n = DONE;
        else if (fill_q)                state_n = WR;
        else                            state_n = RD;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are registered copies of what the next state requires.
    select_n       = (state_n == RD) || (state_n == RD_HOLD) || (state_n == WR);
    write_enable_n = (state_n == WR);
    busy_n         = select_n;
    done_n         = (state_n == DONE);
    addr_n         = addr;
    if (state_n == WR)
      addr_n = {{(ADDR_W-PTR_W){1'b0}}, dst_ptr_n};
    else if ((state_n == RD) || (state_n == RD_HOLD))
      addr_n = {{(ADDR_W-PTR_W){1'b0}}, src_ptr_n};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      remaining    <= '0;
      words_done   <= '0;
      wr_data      <= '0;
      addr         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      select       <= 1'b0;
      write_enable <= 1'b0;
    end else begin
      state        <= state_n;
      src_ptr      <= src_ptr_n;
      dst_ptr      <= dst_ptr_n;
      remaining    <= remaining_n;
      words_done   <= words_done_n;
      wr_data      <= wr_data_n;
      addr         <= addr_n;
      busy         <= busy_n;
      done         <= done_n;
      select       <= select_n;
      write_enable <= write_enable_n;
    end
  end

`ifdef RAM_COPY_FILL_EN
  always_ff @(posedge clk) begin
    if (!rst_n) fill_q <= 1'b0;
    else        fill_q <= fill_n;
  end
`endif

endmodule

// File: doc/ram_block_copy.md
# ram_block_copy

Bus initiator for the 1K word-addressable `ram`. On a single `start` pulse it copies a block of 16-bit words from a source to a destination within the general-purpose region 0x000–0x1FF. It drives the RAM's `addr`/`in_data`/`select`/`write_enable` port and captures `out_data`. It never addresses the register window at 0x200 and above, and it sits beside the CPU datapath as the RAM's second master, arbitrated externally.

## Interface
- `ADDR_W`, default 10: RAM address width; bit 9 is always driven 0.
- `DATA_W`, default 16: word width.
- `PTR_W`, default 9: pointer width; the pointer wraps at 2^PTR_W.
- `clk`, input, 1: system clock; all state changes on posedge.
- `rst_n`, input, 1: reset; synchronous, active-low.
- `start`, input, 1: begin an operation; sampled only in IDLE.
- `src`, input, 9: source word address; latched at start.
- `dst`, input, 9: destination word address; latched at start.
- `len`, input, 10: word count, 0–512; latched at start.
- `fill_mode`, input, 1: write `fill_data` instead of copying; only under `RAM_COPY_FILL_EN`.
- `fill_data`, input, 16: constant for fill; latched at start.
- `busy`, output, 1: high from the cycle after start is accepted until done.
- `done`, output, 1: one-cycle pulse when the operation ends.
- `words_done`, output, 10: count of words written in the current or last operation.
- `addr`, output, 10: RAM address.
- `wr_data`, output, 16: RAM write data; connects to RAM `in_data`.
- `rd_data`, input, 16: RAM read data; connects to RAM `out_data`.
- `select`, output, 1: RAM chip select.
- `write_enable`, output, 1: RAM write strobe.

## Operation
- States: IDLE, RD, RD_HOLD, WR, DONE.
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `words_done`=0, `addr`=0, `wr_data`=0, `select`=0, `write_enable`=0, state=IDLE.
- **IDLE**, on `start`=1:
  - Latch `src`/`dst`/`len`/`fill_data`, clear `words_done`, set `busy`.
  - Next state: DONE if `len`=0; otherwise RD (WR in fill mode).
- **RD**: `select`=1, `write_enable`=0, `addr`={0,src_ptr}. Next state RD_HOLD.
- **RD_HOLD**:
  - Same outputs as RD; the RAM re-reads the same word, so `out_data` is stable.
  - Capture `rd_data` into `wr_data` at the closing posedge. Next state WR.
- **WR**:
  - `select`=1, `write_enable`=1, `addr`={0,dst_ptr}; the RAM commits the write on the negedge within this cycle.
  - At the closing posedge: increment `src_ptr`, `dst_ptr` and `words_done`; decrement `remaining`.
  - Next state: DONE if `remaining` reaches 0; otherwise RD, or WR in fill mode.
- **DONE**: `select`=0, `write_enable`=0, `done`=1, `busy`=0. Next state IDLE.
- Pointer arithmetic:
  - 9-bit modulo; 0x1FF+1 wraps to 0x000.
  - `addr[9]` is constant 0, so the register window is unreachable.
- Overlap: the copy is strictly ascending. If dst > src and the ranges overlap, source words are overwritten before they are read (smear); this is specified behaviour, not an error.
- `start` while `busy` is ignored. `start` held high re-triggers only from IDLE, i.e. on the cycle after DONE.
- `rst_n`=0 mid-operation:
  - At that edge: IDLE, `select`=0, `write_enable`=0, `done` not pulsed.
  - Words already written stay written; `words_done` clears.
- `select` is low in IDLE and DONE, so the RAM tri-states `out_data` whenever the engine is idle.

## Timing
- `start` is accepted at posedge T. The first RD cycle is T+1.
- Copy cost: 3 cycles per word (RD, RD_HOLD, WR).
- Fill cost: 1 cycle per word.
- `done` high in cycle T+3N+1 for a copy, T+N+1 for a fill, and T+1 for `len`=0.
- Read-to-write latency: the word presented at posedge k is captured at k+2 and written during cycle k+2..k+3.
- `words_done` updates at the posedge closing each WR cycle.

## Configuration
- `RAM_COPY_FILL_EN` defined:
  - `fill_mode` is honoured.
  - The fill path skips RD/RD_HOLD and writes the latched `fill_data` to dst..dst+len-1.
- Not defined:
  - `fill_mode` and `fill_data` are ignored and unconnected internally.
  - Every operation is a copy.
  - No fill-mux logic is synthesised.

## Test plan
- Preload ram[0x000]=0xDEAD and ram[0x001]=0xBEEF. Start with src=0x000, dst=0x010, len=2.
  - Required: ram[0x010]=0xDEAD, ram[0x011]=0xBEEF, `done` at T+7, `words_done`=2, `addr[9]` never 1.
- Wrap: src=0x1FE, dst=0x0F0, len=4.
  - Required: reads 0x1FE, 0x1FF, 0x000, 0x001 in order; ram[0x200] (wreg) never selected.
- Start with len=0.
  - Required: `done` at T+1, `select` never asserted, `words_done`=0.
- Pulse `start` again while busy, then drive `rst_n`=0 after the 2nd WR of a len=8 copy.
  - Required: the second start is ignored; exactly 2 destination words are modified; `select`=0 and `busy`=0 on the reset edge; no `done` pulse.
- Overlap: ram[0..3]=1,2,3,4; src=0, dst=1, len=3.
  - Required: ram[0..3]=1,1,1,1.
- With `RAM_COPY_FILL_EN` defined: fill_mode=1, fill_data=0xC0DE, dst=0x100, len=3.
  - Required: ram[0x100..0x102]=0xC0DE, `done` at T+4, `write_enable` high 3 consecutive cycles.
- Without the macro, the same stimulus performs a copy from src instead.
